// File: rtl/echo_pulse_meter.sv
// Echo receiver for the rangefinder: it measures the time-of-flight and width of a returning
// detector pulse, rejects glitches narrower than a minimum, and times out after a listen window.
module echo_pulse_meter #(
    parameter int unsigned CNT_W = 17,
    parameter int unsigned WID_W = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             echo_in,
    input  logic [CNT_W-1:0] window,
    input  logic [WID_W-1:0] min_width,
    output logic             busy,
    output logic             valid,
    output logic             timeout,
    output logic [CNT_W-1:0] tof,
    output logic [WID_W-1:0] width
);

    localparam logic [WID_W-1:0] WID_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        HIGH
    } state_t;

    state_t           state, state_nx;
    logic             echo_m, echo_s, echo_d;
    logic             rise_c, fall_c;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] window_lat, window_lat_nx;
    logic [CNT_W-1:0] rise_cnt, rise_cnt_nx;
    logic [CNT_W-1:0] tof_nx;
    logic [WID_W-1:0] min_width_lat, min_width_lat_nx;
    logic [WID_W-1:0] wcnt, wcnt_nx;
    logic [WID_W-1:0] width_nx;
    logic             busy_nx, valid_nx, timeout_nx;

    // Two-flop synchronizer for the asynchronous detector plus an edge-detect delay stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            echo_m <= 1'b0;
            echo_s <= 1'b0;
            echo_d <= 1'b0;
        end else begin
            echo_m <= echo_in;
            echo_s <= echo_m;
            echo_d <= echo_s;
        end
    end

    assign rise_c = echo_s & ~echo_d;
    assign fall_c = ~echo_s & echo_d;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            window_lat    <= '0;
            rise_cnt      <= '0;
            min_width_lat <= '0;
            wcnt          <= '0;
            tof           <= '0;
            width         <= '0;
            busy          <= 1'b0;
            valid         <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            window_lat    <= window_lat_nx;
            rise_cnt      <= rise_cnt_nx;
            min_width_lat <= min_width_lat_nx;
            wcnt          <= wcnt_nx;
            tof           <= tof_nx;
            width         <= width_nx;
            busy          <= busy_nx;
            valid         <= valid_nx;
            timeout       <= timeout_nx;
        end
    end

    // Next-state and output logic; the window check always wins over echo edges
    always_comb begin
        state_nx         = state;
        cnt_nx           = cnt;
        window_lat_nx    = window_lat;
        rise_cnt_nx      = rise_cnt;
        min_width_lat_nx = min_width_lat;
        wcnt_nx          = wcnt;
        tof_nx           = tof;
        width_nx         = width;
        valid_nx         = 1'b0;
        timeout_nx       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    window_lat_nx    = window;
                    min_width_lat_nx = min_width;
                    cnt_nx           = '0;
                    state_nx         = ARMED;
                end
            end
            ARMED: begin
                if (cnt == window_lat) begin
                    timeout_nx = 1'b1;
                    state_nx   = IDLE;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                    if (rise_c) begin
                        rise_cnt_nx = cnt;
                        wcnt_nx     = WID_W'(1);
                        state_nx    = HIGH;
                    end
                end
            end
            HIGH: begin
                if (cnt == window_lat) begin
                    timeout_nx = 1'b1;
                    state_nx   = IDLE;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                    if (fall_c) begin
                        if (wcnt >= min_width_lat) begin
                            tof_nx   = rise_cnt;
                            width_nx = wcnt;
                            valid_nx = 1'b1;
                            state_nx = IDLE;
                        end else begin
                            state_nx = ARMED;
                        end
                    end else if (echo_s && (wcnt != WID_MAX)) begin
                        wcnt_nx = wcnt + WID_W'(1);
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        busy_nx = (state_nx != IDLE);
    end

endmodule

// File: tb/tb_echo_pulse_meter.sv
// Self-checking bench for echo_pulse_meter: directed vector table, corner sequences and
// randomized measurements checked against a pulse-level reference model.
module tb_echo_pulse_meter;

    localparam int unsigned CNT_W = 17;
    localparam int unsigned WID_W = 15;
    localparam int          WMAX  = 32767;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic             echo_in;
    logic [CNT_W-1:0] window;
    logic [WID_W-1:0] min_width;
    logic             busy;
    logic             valid;
    logic             timeout;
    logic [CNT_W-1:0] tof;
    logic [WID_W-1:0] width;

    echo_pulse_meter #(.CNT_W(CNT_W), .WID_W(WID_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .echo_in   (echo_in),
        .window    (window),
        .min_width (min_width),
        .busy      (busy),
        .valid     (valid),
        .timeout   (timeout),
        .tof       (tof),
        .width     (width)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int last_tof = 0;
    int last_wid = 0;

    // Echo pulses of the current measurement: echo_in is high in the cycles after edges
    // E0+n .. E0+n+l-1; a negative n means the echo was already high before start.
    int pn[4];
    int pl[4];
    int np;

    typedef struct {
        int win;
        int minw;
        int n0;
        int l0;
        int n1;
        int l1;
        int ign;
        bit ev;
        int etof;
        int ewid;
        int eedge;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit level(input int k);
        for (int i = 0; i < np; i++)
            if (pn[i] <= k && k < pn[i] + pl[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Pulse-level outcome: each echo reaches the counter two cycles late; the window wins ties.
    task automatic model(input int win, input int minw, output bit ev, output int etof,
                         output int ewid, output int eedge);
        int r;
        int f;
        ev    = 1'b0;
        etof  = 0;
        ewid  = 0;
        eedge = win + 1;
        for (int i = 0; i < np; i++) begin
            if (pn[i] < 0) continue;
            r = pn[i] + 2;
            f = pn[i] + pl[i] + 2;
            if (r >= win || f >= win) break;
            if (pl[i] >= minw) begin
                ev    = 1'b1;
                etof  = r;
                ewid  = (pl[i] > WMAX) ? WMAX : pl[i];
                eedge = f + 1;
                break;
            end
        end
    endtask

    task automatic run_meas(input string name, input int win, input int minw, input bit keep_echo,
                            input int ign_k, input bit ev, input int etof, input int ewid,
                            input int eedge);
        bit got_v;
        bit got_t;
        bit busy_ok;
        int got_edge;
        int xtof;
        int xwid;
        got_v    = 1'b0;
        got_t    = 1'b0;
        busy_ok  = 1'b1;
        got_edge = -1;
        if (!keep_echo) begin
            echo_in = 1'b0;
            @(posedge clk); #1;
            chk({name, "_strobe_len"}, int'(valid | timeout), 0);
            repeat (3) @(posedge clk);
            #1;
        end
        window    = CNT_W'(win);
        min_width = WID_W'(minw);
        start     = 1'b1;
        echo_in   = level(-1);
        @(posedge clk); #1;
        start = 1'b0;
        chk({name, "_busy_start"}, int'(busy), 1);
        for (int k = 0; k <= win + 5 && got_edge < 0; k++) begin
            echo_in = level(k);
            if (k == ign_k) begin
                start     = 1'b1;
                window    = CNT_W'(3);
                min_width = WID_W'(50);
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (valid || timeout) begin
                got_v    = valid;
                got_t    = timeout;
                got_edge = k + 1;
            end else if (!busy) begin
                busy_ok = 1'b0;
            end
        end
        xtof = ev ? etof : last_tof;
        xwid = ev ? ewid : last_wid;
        chk({name, "_valid"}, int'(got_v), int'(ev));
        chk({name, "_timeout"}, int'(got_t), int'(!ev));
        chk({name, "_edge"}, got_edge, eedge);
        chk({name, "_tof"}, int'(tof), xtof);
        chk({name, "_width"}, int'(width), xwid);
        chk({name, "_busy_hold"}, int'(busy_ok), 1);
        chk({name, "_busy_end"}, int'(busy), 0);
        last_tof = xtof;
        last_wid = xwid;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ev;
        int etof;
        int ewid;
        int eedge;
        int win;
        int minw;
        int t;
        int ign;

        tbl[0]  = '{1000, 4, 100, 10,   0, 0, -1, 1'b1, 102, 10, 113};
        tbl[1]  = '{1000, 5,  50,  3, 200, 8, -1, 1'b1, 202,  8, 211};
        tbl[2]  = '{ 300, 4,   0,  0,   0, 0, -1, 1'b0,   0,  0, 301};
        tbl[3]  = '{   0, 4,   0,  0,   0, 0, -1, 1'b0,   0,  0,   1};
        tbl[4]  = '{  12, 1,  10,  5,   0, 0, -1, 1'b0,   0,  0,  13};
        tbl[5]  = '{  20, 1,  10,  8,   0, 0, -1, 1'b0,   0,  0,  21};
        tbl[6]  = '{  21, 1,  10,  8,   0, 0, -1, 1'b1,  12,  8,  21};
        tbl[7]  = '{ 100, 6,   0,  6,   0, 0, -1, 1'b1,   2,  6,   9};
        tbl[8]  = '{ 100, 7,   0,  6,   0, 0, -1, 1'b0,   0,  0, 101};
        tbl[9]  = '{ 500, 2,  30,  4,   0, 0, 10, 1'b1,  32,  4,  37};
        tbl[10] = '{  50, 0,   5,  1,   0, 0, -1, 1'b1,   7,  1,   9};

        reset_n   = 1'b0;
        start     = 1'b0;
        echo_in   = 1'b0;
        window    = '0;
        min_width = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_timeout", int'(timeout), 0);
        chk("reset_tof", int'(tof), 0);
        chk("reset_width", int'(width), 0);
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            np = 0;
            if (tbl[i].l0 > 0) begin pn[np] = tbl[i].n0; pl[np] = tbl[i].l0; np++; end
            if (tbl[i].l1 > 0) begin pn[np] = tbl[i].n1; pl[np] = tbl[i].l1; np++; end
            run_meas($sformatf("vec%0d", i), tbl[i].win, tbl[i].minw, 1'b0, tbl[i].ign,
                     tbl[i].ev, tbl[i].etof, tbl[i].ewid, tbl[i].eedge);
        end

        // Echo stuck high, then re-arm in the timeout cycle with the echo still high
        np = 1; pn[0] = 20; pl[0] = 100000;
        run_meas("stuck", 100, 1, 1'b0, -1, 1'b0, 0, 0, 101);
        np = 2; pn[0] = -5; pl[0] = 15; pn[1] = 18; pl[1] = 6;
        run_meas("stuck_rearm", 60, 2, 1'b1, -1, 1'b1, 20, 6, 27);

        // Reset asserted while the echo is high aborts without a strobe
        echo_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        window    = CNT_W'(200);
        min_width = WID_W'(2);
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 15; k++) begin
            echo_in = (k >= 5);
            @(posedge clk); #1;
        end
        #2 reset_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(valid), 0);
        chk("abort_timeout", int'(timeout), 0);
        chk("abort_tof", int'(tof), 0);
        chk("abort_width", int'(width), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_strobe", int'(valid | timeout | busy), 0);
        echo_in  = 1'b0;
        reset_n  = 1'b1;
        last_tof = 0;
        last_wid = 0;
        np = 1; pn[0] = 40; pl[0] = 7;
        run_meas("post_reset", 500, 3, 1'b0, -1, 1'b1, 42, 7, 50);

        // Width counter saturation on a very long echo
        np = 1; pn[0] = 0; pl[0] = 33000;
        run_meas("saturate", 40000, 10, 1'b0, -1, 1'b1, 2, WMAX, 33003);

        for (int r = 0; r < 40; r++) begin
            win  = int'($urandom_range(0, 400));
            minw = int'($urandom_range(0, 12));
            np   = int'($urandom_range(0, 3));
            t    = int'($urandom_range(0, 60));
            for (int i = 0; i < np; i++) begin
                pn[i] = t;
                pl[i] = int'($urandom_range(1, 20));
                t     = t + pl[i] + int'($urandom_range(1, 60));
            end
            model(win, minw, ev, etof, ewid, eedge);
            ign = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, eedge - 1)) : -1;
            run_meas($sformatf("rand%0d", r), win, minw, 1'b0, ign, ev, etof, ewid, eedge);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
